ddr_port_tester: RTL

Parametrised self-checking traffic generator for one MIG user port on the DDR2 interface. After calibration it writes a configurable number of bursts using a selectable data pattern, reads each burst back, and compares every word. It reports errors, the first failing address, and a pass count. It replaces the fixed six-word write/read smoke test, sits beside `ddr_interface`, and drives one `c3_pN_*` port set.

---
 rtl/ddr_port_tester.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/ddr_port_tester.sv
// Self-checking traffic generator for one MIG user port: fills bursts with a
// selectable pattern, writes them, reads them back and compares every word.
module ddr_port_tester #(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 30,
  parameter int BL         = 16,
  parameter int NUM_BURSTS = 4,
  parameter int BASE_ADDR  = 0,
  parameter int TIMEOUT_W  = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  calib_done,
  input  logic                  start,
  input  logic                  loop_en,
  input  logic [1:0]            mode,
  output logic                  cmd_en,
  output logic [2:0]            cmd_instr,
  output logic [5:0]            cmd_bl,
  output logic [ADDR_W-1:0]     cmd_byte_addr,
  input  logic                  cmd_full,
  output logic                  wr_en,
  output logic [DATA_W-1:0]     wr_data,
  output logic [DATA_W/8-1:0]   wr_mask,
  input  logic                  wr_full,
  output logic                  rd_en,
  input  logic [DATA_W-1:0]     rd_data,
  input  logic                  rd_empty,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic [15:0]           err_count,
  output logic [ADDR_W-1:0]     first_err_addr,
  output logic [15:0]           pass_count
);
  localparam int BYTES = DATA_W / 8;
  localparam int WW    = $clog2(BL + 1);
  localparam int BW    = $clog2(NUM_BURSTS + 1);
  localparam logic [WW-1:0]        W_LAST  = WW'(BL - 1);
  localparam logic [BW-1:0]        B_LAST  = BW'(NUM_BURSTS - 1);
  localparam logic [TIMEOUT_W-1:0] WD_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
  localparam logic [DATA_W-1:0]    ONE     = {{(DATA_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_CAL, S_FILL, S_WR_CMD, S_RD_CMD, S_DRAIN, S_DONE, S_ERR_TO
  } state_t;

  state_t                state_q, state_d;
  logic [BW-1:0]         b_q, b_d;
  logic [WW-1:0]         w_q, w_d;
  logic [1:0]            mode_q, mode_d;
  logic [TIMEOUT_W-1:0]  wd_q, wd_d;
  logic [15:0]           err_q, err_d, pc_q, pc_d;
  logic [ADDR_W-1:0]     first_q, first_d;
  logic                  to_q, to_d;
  logic                  cal_s1_q, cal_s2_q;
  logic                  busy_q, done_q, pass_q;
  logic [DATA_W-1:0]     wr_data_q, wr_data_d;
  logic [2:0]            cmd_instr_q;
  logic [5:0]            cmd_bl_q;
  logic [ADDR_W-1:0]     cmd_addr_q, cmd_addr_d;

  function automatic logic [ADDR_W-1:0] word_addr(logic [BW-1:0] b, logic [WW-1:0] w);
    logic [31:0] n;
    n = 32'(b) * 32'(BL) + 32'(w);
    return ADDR_W'(BASE_ADDR) + ADDR_W'(n * 32'(BYTES));
  endfunction

  function automatic logic [DATA_W-1:0] pattern(logic [1:0] m, logic [BW-1:0] b,
                                                logic [WW-1:0] w);
    logic [31:0]       n;
    logic [DATA_W-1:0] p;
    n = 32'(b) * 32'(BL) + 32'(w);
    case (m)
      2'd0:    p = DATA_W'(n);
      2'd1:    p = DATA_W'(word_addr(b, w));
      2'd2:    p = ~DATA_W'(word_addr(b, w));
      default: p = ONE << (n % 32'(DATA_W));
    endcase
    return p;
  endfunction

  always_comb begin
    state_d = state_q;
    b_d     = b_q;
    w_d     = w_q;
    mode_d  = mode_q;
    wd_d    = '0;
    err_d   = err_q;
    first_d = first_q;
    to_d    = to_q;
    pc_d    = pc_q;
    cmd_en  = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          err_d   = '0;
          first_d = '0;
          to_d    = 1'b0;
          pc_d    = '0;
          b_d     = '0;
          w_d     = '0;
          mode_d  = mode;
          state_d = S_WAIT_CAL;
        end
      end
      S_WAIT_CAL: if (cal_s2_q) state_d = S_FILL;
      S_FILL: begin
        wr_en = !wr_full;
        if (wr_en) begin
          if (w_q == W_LAST) begin
            w_d     = '0;
            state_d = S_WR_CMD;
          end else begin
            w_d = w_q + WW'(1);
          end
        end
      end
      S_WR_CMD: begin
        cmd_en = !cmd_full;
        if (cmd_en) state_d = S_RD_CMD;
      end
      S_RD_CMD: begin
        cmd_en = !cmd_full;
        if (cmd_en) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        rd_en = !rd_empty;
        if (rd_en) begin
          // first_err_addr only latches while the error count is still zero
          if (rd_data != pattern(mode_q, b_q, w_q)) begin
            if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
            if (err_q == 16'd0) first_d = word_addr(b_q, w_q);
          end
          if (w_q == W_LAST) begin
            w_d = '0;
            if (b_q == B_LAST) begin
              b_d     = '0;
              pc_d    = pc_q + 16'd1;
              state_d = loop_en ? S_FILL : S_DONE;
            end else begin
              b_d     = b_q + BW'(1);
              state_d = S_FILL;
            end
          end else begin
            w_d = w_q + WW'(1);
          end
        end else if (wd_q == WD_LAST) begin
          to_d    = 1'b1;
          state_d = S_ERR_TO;
        end else begin
          wd_d = wd_q + TIMEOUT_W'(1);
        end
      end
      S_ERR_TO: ;
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs are precomputed from next-state values so they line up
  // with the state they belong to.
  assign wr_data_d  = pattern(mode_d, b_d, w_d);
  assign cmd_addr_d = word_addr(b_d, '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      b_q         <= '0;
      w_q         <= '0;
      mode_q      <= '0;
      wd_q        <= '0;
      err_q       <= '0;
      first_q     <= '0;
      to_q        <= 1'b0;
      pc_q        <= '0;
      cal_s1_q    <= 1'b0;
      cal_s2_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      wr_data_q   <= '0;
      cmd_instr_q <= 3'b000;
      cmd_bl_q    <= '0;
      cmd_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      b_q         <= b_d;
      w_q         <= w_d;
      mode_q      <= mode_d;
      wd_q        <= wd_d;
      err_q       <= err_d;
      first_q     <= first_d;
      to_q        <= to_d;
      pc_q        <= pc_d;
      cal_s1_q    <= calib_done;
      cal_s2_q    <= cal_s1_q;
      busy_q      <= (state_d != S_IDLE) && (state_d != S_DONE);
      done_q      <= (state_d == S_DONE);
      pass_q      <= (state_d == S_DONE) && (err_d == 16'd0) && !to_d;
      wr_data_q   <= wr_data_d;
      cmd_instr_q <= (state_d == S_RD_CMD) ? 3'b001 : 3'b000;
      cmd_bl_q    <= 6'(BL - 1);
      cmd_addr_q  <= cmd_addr_d;
    end
  end

  assign cmd_instr      = cmd_instr_q;
  assign cmd_bl         = cmd_bl_q;
  assign cmd_byte_addr  = cmd_addr_q;
  assign wr_data        = wr_data_q;
  assign wr_mask        = '0;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign timeout        = to_q;
  assign err_count      = err_q;
  assign first_err_addr = first_q;
  assign pass_count     = pc_q;
endmodule
